memory_control: RTL
===================

MEMORY_CONTROL -- requirements
Module: memory_control

Interface
REQ-001 SHALL have parameter BUSY_LIMIT, default 15, max consecutive non-ACCESS cycles in one grant before memerr sets.
REQ-002 SHALL have port CLK  in  1  single clock, rising edge.
REQ-003 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports iREN  in  1  icache read request; iaddr  in  32  icache word address.
REQ-005 SHALL have ports dREN, dWEN  in  1 each  dcache read/write request; daddr  in  32; dstore  in  32  write data.
REQ-006 SHALL have ports iwait, dwait  out  1 each  high = request not complete; iload, dload  out  32  read data.
REQ-007 SHALL have ports ramREN, ramWEN  out  1 each; ramaddr, ramstore  out  32; ramload  in  32; ramstate  in  2 (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-008 SHALL have port memerr  out  1  sticky RAM error/timeout flag.

Function
REQ-009 SHALL implement FSM states IDLE, DGNT, IGNT; ram outputs are driven only in DGNT/IGNT.
REQ-010 SHALL, in IDLE with any request, go to DGNT if dREN|dWEN, else IGNT if iREN, next edge; else stay IDLE.
REQ-011 SHALL, in DGNT, drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted).
REQ-012 SHALL, in IGNT, drive ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
REQ-013 SHALL, when ramstate==ACCESS in a grant state, drive granted wait low combinationally in that cycle, load=ramload for that cycle, then return to IDLE.
REQ-014 SHALL hold both waits high in all other cycles; ungranted port's wait is always high.
REQ-015 SHALL register iload/dload only on the completion cycle and hold the value until the next completion on that port.
REQ-016 SHALL return to IDLE without a wait pulse if the granted cache drops its request mid-grant.
REQ-017 SHALL keep the grant while ramstate is FREE, BUSY or ERROR; ERROR sets memerr.
REQ-018 SHALL count consecutive non-ACCESS cycles per grant (counter clears on grant entry); reaching BUSY_LIMIT sets memerr; grant is not aborted.
REQ-019 SHALL give min latency of 2 cycles from request assertion in IDLE to wait low (grant edge plus ACCESS cycle); back-to-back requests incur one IDLE cycle.
REQ-020 SHALL never assert ramREN and ramWEN together.

Reset
REQ-021 SHALL, on nRST low, asynchronously force IDLE, iwait=dwait=1, iload=dload=0, ram enables/addr/store=0, counter=0, memerr=0.
REQ-022 SHALL abandon an in-flight grant on reset, with no wait pulse and no load update.

Configuration
REQ-023 SHALL, with ARB_FAIR_EN defined, grant IGNT from IDLE when both ports request and the previous completed grant was DGNT.
REQ-024 SHALL, without ARB_FAIR_EN, use fixed dcache priority per REQ-010.

Verification
REQ-025 SHALL cover: iREN=1, iaddr=0x40, RAM ACCESS on 1st grant cycle, ramload=0xDEADBEEF -> iwait low exactly cycle 2, iload=0xDEADBEEF.
REQ-026 SHALL cover: dREN=dWEN=iREN=1 -> DGNT, ramWEN=1, ramREN=0, ramaddr=daddr; after completion, without ARB_FAIR_EN next grant DGNT, with it IGNT.
REQ-027 SHALL cover: RAM BUSY 20 cycles with BUSY_LIMIT=15 -> memerr rises on 15th non-ACCESS cycle, stays high after completion.
REQ-028 SHALL cover: nRST low mid-DGNT -> same-cycle IDLE, dwait=1, ramWEN=0, dload unchanged at 0.
REQ-029 SHALL cover: iREN dropped on 2nd IGNT cycle before ACCESS -> IDLE next edge, iwait never low, iload unchanged.

Source files
------------

// File: rtl/memory_control.sv
// ---------------------------------------------------------------------------
// memory_control
//
// Arbitrates a single-ported RAM between an instruction cache (read only)
// and a data cache (read/write). A three-state FSM (IDLE, DGNT, IGNT) holds
// the grant. The RAM-side outputs are decoded from the registered grant
// state, so they are zero whenever the FSM is in IDLE or held in reset.
//
// A grant completes in the cycle where the RAM reports ACCESS while the
// granted cache is still requesting. In that cycle the granted wait drops
// combinationally and the load bus carries ramload directly. The same value
// is captured and held until the next completion on that port.
//
// memerr is sticky until reset. It is set by a RAM ERROR status during a
// grant, or when a single grant has seen BUSY_LIMIT non-ACCESS cycles in a
// row. Neither condition aborts the grant.
//
// Optional feature (macro ARB_FAIR_EN):
//   When defined, a simultaneous icache + dcache request in IDLE goes to the
//   icache if the previous completed grant served the dcache. When it is
//   undefined, the dcache always has priority.
//
// Parameters
//   BUSY_LIMIT : non-ACCESS cycles in one grant that set memerr (>= 1)
//
// Ports
//   CLK, nRST          : clock (rising edge), asynchronous active-low reset
//   iREN, iaddr        : icache read request and word address
//   dREN, dWEN         : dcache read / write request
//   daddr, dstore      : dcache address and write data
//   iwait, dwait       : high while the port's request is not complete
//   iload, dload       : read data returned to each cache
//   ramREN, ramWEN     : RAM read / write enables (never both high)
//   ramaddr, ramstore  : RAM address and write data
//   ramload            : RAM read data
//   ramstate           : RAM status FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   memerr             : sticky RAM error / timeout flag
// ---------------------------------------------------------------------------
module memory_control #(
  parameter int BUSY_LIMIT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int CNT_W = (BUSY_LIMIT < 1) ? 1 : $clog2(BUSY_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(BUSY_LIMIT);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_memerr;
  logic [31:0]      r_iload;
  logic [31:0]      r_dload;

  logic             w_dreq;
  logic             w_access;
  logic             w_dlive;
  logic             w_ilive;
  logic             w_dcomp;
  logic             w_icomp;
  logic             w_pick_i;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == RS_ACCESS);

  // A grant is only "live" while its cache keeps requesting; a dropped
  // request ends the grant without ever producing a completion.
  assign w_dlive  = (r_state == DGNT) & w_dreq;
  assign w_ilive  = (r_state == IGNT) & iREN;
  assign w_dcomp  = w_dlive & w_access;
  assign w_icomp  = w_ilive & w_access;

  // Saturating so a very long stall cannot wrap the counter back below
  // the limit.
  assign w_cnt_nxt = (r_cnt == LIMIT) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef ARB_FAIR_EN
  // Remembers which port the most recent completed grant served.
  logic r_last_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_d <= 1'b0;
    end else if (w_dcomp) begin
      r_last_d <= 1'b1;
    end else if (w_icomp) begin
      r_last_d <= 1'b0;
    end
  end

  assign w_pick_i = iREN & (~w_dreq | r_last_d);
`else
  assign w_pick_i = iREN & ~w_dreq;
`endif

  // Grant FSM, busy counter, error flag and load capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_memerr <= 1'b0;
      r_iload  <= '0;
      r_dload  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Every grant is entered from IDLE, so clearing here gives each
          // grant a fresh count.
          r_cnt <= '0;
          if (w_pick_i) begin
            r_state <= IGNT;
          end else if (w_dreq) begin
            r_state <= DGNT;
          end
        end

        DGNT, IGNT: begin
          if (!(w_dlive | w_ilive)) begin
            r_state <= IDLE;
          end else if (w_access) begin
            r_state <= IDLE;
            if (r_state == DGNT) begin
              r_dload <= ramload;
            end else begin
              r_iload <= ramload;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == LIMIT || ramstate == RS_ERROR) begin
              r_memerr <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // RAM side decode: only a grant state drives the bus.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      IGNT: begin
        ramaddr  = iaddr;
        ramREN   = iREN;
      end
      default: begin
        ramREN   = 1'b0;
      end
    endcase
  end

  // Cache side: wait drops and the load bus passes ramload through only
  // in the completion cycle; otherwise the captured value is held.
  assign iwait  = ~w_icomp;
  assign dwait  = ~w_dcomp;
  assign iload  = w_icomp ? ramload : r_iload;
  assign dload  = w_dcomp ? ramload : r_dload;
  assign memerr = r_memerr;

endmodule
